// File: rtl/ic_pkg.sv
// Shared defaults and helpers for the image-capture read FIFO.
package ic_pkg;

  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned DEPTH_DEF        = 16;
  localparam int unsigned AFULL_MARGIN_DEF = 4;
  localparam int unsigned BLOCK_WORDS_DEF  = 48;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ic_fifo_mem.sv
// Storage array behind the output register: simple dual-port, synchronous
// write, asynchronous read.
module ic_fifo_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SLOTS  = 15,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [SLOTS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ic_read_fifo.sv
// Read-side FIFO between the master read stage and the colour converter.
// First-word fall-through via an output register; counts pops per RGB block.
module ic_read_fifo
  import ic_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned AFULL_MARGIN = AFULL_MARGIN_DEF,
  parameter int unsigned BLOCK_WORDS  = BLOCK_WORDS_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      ff_writerequest,
  input  logic [DATA_W-1:0]         ff_writedata,
  output logic                      ff_full,
  output logic                      ff_empty,
  output logic [cnt_w(DEPTH)-1:0]   ff_count,
  output logic                      ff_overflow,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_waitrequest,
  output logic                      block_done
);

  localparam int unsigned CW    = cnt_w(DEPTH);
  localparam int unsigned SLOTS = DEPTH - 1;
  localparam int unsigned AW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned BW    = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  // Storage slots are not a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(SLOTS - 1)) ? '0 : p + AW'(1);
  endfunction

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              ovf_q, ovf_d;
  logic [BW-1:0]     blk_q, blk_d;
  logic              bdone_q, bdone_d;

  logic              pop, wr_acc, wr_drop, st_empty, bypass, mem_we;
  logic [CW-1:0]     st_cnt;
  logic [DATA_W-1:0] mem_rdata;

  ic_fifo_mem #(
    .DATA_W (DATA_W),
    .SLOTS  (SLOTS),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (ff_writedata),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    pop      = out_valid_q && !out_waitrequest;
    st_cnt   = cnt_q - CW'(out_valid_q);
    st_empty = (st_cnt == '0);
    // Space is judged on the registered count; a same-cycle pop does not help.
    wr_acc   = ff_writerequest && !flush && (cnt_q <  CW'(DEPTH));
    wr_drop  = ff_writerequest && !flush && (cnt_q == CW'(DEPTH));
    bypass   = wr_acc && (!out_valid_q || (pop && st_empty));
    mem_we   = wr_acc && !bypass;

    cnt_d       = cnt_q + CW'(wr_acc) - CW'(pop);
    wr_ptr_d    = mem_we ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q | wr_drop;
    blk_d       = blk_q;
    bdone_d     = 1'b0;

    if (pop) begin
      if (!st_empty) begin
        out_data_d = mem_rdata;
        rd_ptr_d   = ptr_inc(rd_ptr_q);
      end else if (wr_acc) begin
        out_data_d = ff_writedata;
      end else begin
        out_valid_d = 1'b0;
      end
      if (blk_q == BW'(BLOCK_WORDS - 1)) begin
        blk_d   = '0;
        bdone_d = 1'b1;
      end else begin
        blk_d = blk_q + BW'(1);
      end
    end else if (bypass) begin
      out_data_d  = ff_writedata;
      out_valid_d = 1'b1;
    end

    if (flush) begin
      cnt_d       = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
      blk_d       = '0;
      bdone_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
      blk_q       <= '0;
      bdone_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
      blk_q       <= blk_d;
      bdone_q     <= bdone_d;
    end
  end

  assign ff_count    = cnt_q;
  assign ff_empty    = (cnt_q == '0);
  assign ff_full     = (cnt_q >= CW'(DEPTH - AFULL_MARGIN));
  assign ff_overflow = ovf_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign block_done  = bdone_q;

endmodule
